// File: rtl/bus_codes_pkg.sv
// rtl/bus_codes_pkg.sv - shared bus source/destination code constants
//
// Purpose: code widths, one-hot width, command record and the named
// source/destination codes shared by the control unit, the sequencer and
// the bench.
// Ports: none (package).
package bus_codes_pkg;

  localparam int NUM_CODES = 24;
  localparam int CODE_W    = 5;

  typedef logic [CODE_W-1:0]    code_t;
  typedef logic [NUM_CODES-1:0] onehot_t;

  typedef struct packed {
    code_t src;
    code_t dst;
  } xfer_cmd_t;

  // Source codes (bus drivers)
  localparam code_t SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3;
  localparam code_t SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7;
  localparam code_t SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11;
  localparam code_t SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
  localparam code_t SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHIGH = 5'd18, SRC_ZLOW = 5'd19;
  localparam code_t SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C  = 5'd23;

  // Destination codes (bus receivers)
  localparam code_t DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3;
  localparam code_t DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7;
  localparam code_t DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11;
  localparam code_t DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15;
  localparam code_t DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd18, DST_MDR = 5'd19;
  localparam code_t DST_MAR = 5'd20, DST_IR  = 5'd21, DST_Y   = 5'd22, DST_OUTPORT = 5'd23;

  function automatic logic code_is_legal(input code_t code);
    return code < code_t'(NUM_CODES);
  endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// rtl/bus_xfer_sequencer_if.sv - command handshake and one-hot enable bundle
//
// Purpose: groups the command handshake and the one-hot bus enables.
// Ports (signals):
//   req_valid/req_src/req_dst  control unit -> sequencer command
//   req_ready                  sequencer -> control unit, FIFO not full
//   out_en/in_en               sequencer -> datapath one-hot enables
// Modports: master = control unit side, slave = sequencer side.
interface bus_xfer_sequencer_if import bus_codes_pkg::*; ;

  logic    req_valid;
  logic    req_ready;
  code_t   req_src;
  code_t   req_dst;
  onehot_t out_en;
  onehot_t in_en;

  modport master (output req_valid, req_src, req_dst,
                  input  req_ready, out_en, in_en);

  modport slave  (input  req_valid, req_src, req_dst,
                  output req_ready, out_en, in_en);

endinterface

// File: rtl/bus_code_decoder.sv
// rtl/bus_code_decoder.sv - 5-bit bus code to 24-bit one-hot decoder
//
// Purpose: purely combinational decode of one source or destination code.
// Ports:
//   code    in   5-bit code
//   onehot  out  24-bit one-hot, all zero when the code is illegal
//   legal   out  code < NUM_CODES
module bus_code_decoder
  import bus_codes_pkg::*;
(
  input  code_t   code,
  output onehot_t onehot,
  output logic    legal
);

  always_comb begin
    legal  = code_is_legal(code);
    onehot = '0;
    if (legal) onehot = onehot_t'(1) << code;
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// rtl/bus_xfer_sequencer.sv - queued one-cycle register transfer issuer
//
// Purpose: buffers (src, dst) code pairs in a DEPTH-entry FIFO and issues
// each as one bus cycle of registered one-hot out/in enables.
// Ports:
//   clk          in   datapath clock
//   clr          in   synchronous active-high reset
//   bus          slave modport: req_valid/req_ready/req_src/req_dst in,
//                out_en/in_en registered one-hot enables out
//   hold         in   stall, no pop while high
//   busy         out  queue non-empty or transfer on the bus this cycle
//   err_illegal  out  sticky, an illegal code was popped
//   xfer_count   out  completed legal transfers, wrapping
module bus_xfer_sequencer
  import bus_codes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                clr,
  bus_xfer_sequencer_if.slave bus,
  input  logic                hold,
  output logic                busy,
  output logic                err_illegal,
  output logic [15:0]         xfer_count
);

  localparam int AW = $clog2(DEPTH);

  xfer_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  onehot_t out_en_q;
  onehot_t in_en_q;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  xfer_cmd_t head;

  onehot_t src_oh;
  onehot_t dst_oh;
  logic    src_legal;
  logic    dst_legal;
  logic    head_legal;

  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);
  // A full queue refuses the push even when it pops on the same edge.
  assign push  = bus.req_valid && !full;
  assign pop   = !empty && !hold;
  assign head  = mem[rd_ptr];

  bus_code_decoder u_src_dec (
    .code   (head.src),
    .onehot (src_oh),
    .legal  (src_legal)
  );

  bus_code_decoder u_dst_dec (
    .code   (head.dst),
    .onehot (dst_oh),
    .legal  (dst_legal)
  );

  assign head_legal = src_legal && dst_legal;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      out_en_q    <= '0;
      in_en_q     <= '0;
      err_illegal <= 1'b0;
      xfer_count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{src: bus.req_src, dst: bus.req_dst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      // Enables are loaded every edge, so they self-clear after one cycle.
      if (pop && head_legal) begin
        out_en_q   <= src_oh;
        in_en_q    <= dst_oh;
        xfer_count <= xfer_count + 16'd1;
      end else begin
        out_en_q <= '0;
        in_en_q  <= '0;
      end

      if (pop && !head_legal) err_illegal <= 1'b1;
    end
  end

  assign bus.out_en    = out_en_q;
  assign bus.in_en     = in_en_q;
  assign bus.req_ready = !full;
  assign busy          = (occ != '0) || (out_en_q != '0);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb/tb_bus_xfer_sequencer.sv - directed self-checking bench for bus_xfer_sequencer
module tb_bus_xfer_sequencer;
  import bus_codes_pkg::*;

  logic        clk;
  logic        clr;
  logic        hold;
  logic        busy;
  logic        err_illegal;
  logic [15:0] xfer_count;

  int checks;
  int failures;

  bus_xfer_sequencer_if bif ();

  bus_xfer_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bif.slave),
    .hold        (hold),
    .busy        (busy),
    .err_illegal (err_illegal),
    .xfer_count  (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; hold = 1'b0;
    bif.req_valid = 1'b0; bif.req_src = '0; bif.req_dst = '0;
    tick();
    clr = 1'b0;
    checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready actual=%b required=1", bif.req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", busy); end
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL rst_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (bif.in_en !== 24'h0) begin failures++; $display("FAIL rst_in_en actual=%h required=000000", bif.in_en); end
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL rst_err actual=%b required=0", err_illegal); end
    checks++; if (xfer_count !== 16'h0) begin failures++; $display("FAIL rst_count actual=%h required=0000", xfer_count); end

    // Mid-stream clear with 3 entries queued.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.req_valid = 1'b1; bif.req_src = code_t'(i); bif.req_dst = code_t'(i + 1);
      tick();
    end
    bif.req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_q3_busy actual=%b required=1", busy); end
    clr = 1'b1;
    tick();
    clr = 1'b0; hold = 1'b0;
    checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL clr_ready actual=%b required=1", bif.req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy actual=%b required=0", busy); end
    checks++; if (xfer_count !== 16'h0) begin failures++; $display("FAIL clr_count actual=%h required=0000", xfer_count); end
    tick();
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL clr_discard_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_discard_busy actual=%b required=0", busy); end
  endtask

  task automatic test_single();
    bif.req_valid = 1'b1; bif.req_src = SRC_PC; bif.req_dst = DST_MAR;
    tick();
    bif.req_valid = 1'b0;
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL single_pre_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_pre_busy actual=%b required=1", busy); end
    tick();
    checks++; if (bif.out_en !== 24'h100000) begin failures++; $display("FAIL single_out_en actual=%h required=100000", bif.out_en); end
    checks++; if (bif.in_en !== 24'h100000) begin failures++; $display("FAIL single_in_en actual=%h required=100000", bif.in_en); end
    checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL single_count actual=%0d required=1", xfer_count); end
    tick();
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL single_post_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (bif.in_en !== 24'h0) begin failures++; $display("FAIL single_post_in_en actual=%h required=000000", bif.in_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_post_busy actual=%b required=0", busy); end
  endtask

  task automatic test_fill_stream();
    code_t   s [5];
    code_t   d [5];
    logic    exp_ready;
    onehot_t exp_out, exp_in;
    s = '{SRC_R1, SRC_R3, SRC_HI, SRC_C, SRC_R7};
    d = '{DST_R2, DST_R3, DST_LO, DST_OUTPORT, DST_R8};
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bif.req_valid = 1'b1; bif.req_src = s[i]; bif.req_dst = d[i];
      exp_ready = (i < 4);
      checks++; if (bif.req_ready !== exp_ready) begin failures++; $display("FAIL fill_ready_%0d actual=%b required=%b", i, bif.req_ready, exp_ready); end
      tick();
      checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL fill_hold_out_en_%0d actual=%h required=000000", i, bif.out_en); end
    end
    bif.req_valid = 1'b0;
    checks++; if (bif.req_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready actual=%b required=0", bif.req_ready); end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_out = onehot_t'(1) << s[i];
      exp_in  = onehot_t'(1) << d[i];
      checks++; if (bif.out_en !== exp_out) begin failures++; $display("FAIL stream_out_en_%0d actual=%h required=%h", i, bif.out_en, exp_out); end
      checks++; if (bif.in_en !== exp_in) begin failures++; $display("FAIL stream_in_en_%0d actual=%h required=%h", i, bif.in_en, exp_in); end
      checks++; if (xfer_count !== 16'(2 + i)) begin failures++; $display("FAIL stream_count_%0d actual=%0d required=%0d", i, xfer_count, 2 + i); end
    end
    tick();
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL stream_end_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_end_busy actual=%b required=0", busy); end
  endtask

  task automatic test_illegal();
    bif.req_valid = 1'b1; bif.req_src = 5'd25; bif.req_dst = DST_R3;
    tick();
    bif.req_src = SRC_R5; bif.req_dst = DST_Y;
    tick();
    bif.req_valid = 1'b0;
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL illegal_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (bif.in_en !== 24'h0) begin failures++; $display("FAIL illegal_in_en actual=%h required=000000", bif.in_en); end
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL illegal_err actual=%b required=1", err_illegal); end
    checks++; if (xfer_count !== 16'd5) begin failures++; $display("FAIL illegal_count actual=%0d required=5", xfer_count); end
    tick();
    checks++; if (bif.out_en !== 24'h000020) begin failures++; $display("FAIL legal_after_out_en actual=%h required=000020", bif.out_en); end
    checks++; if (bif.in_en !== 24'h400000) begin failures++; $display("FAIL legal_after_in_en actual=%h required=400000", bif.in_en); end
    checks++; if (xfer_count !== 16'd6) begin failures++; $display("FAIL legal_after_count actual=%0d required=6", xfer_count); end
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL err_sticky actual=%b required=1", err_illegal); end
    // Illegal destination only.
    bif.req_valid = 1'b1; bif.req_src = SRC_R4; bif.req_dst = 5'd30;
    tick();
    bif.req_valid = 1'b0;
    tick();
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL illegal_dst_out_en actual=%h required=000000", bif.out_en); end
    checks++; if (xfer_count !== 16'd6) begin failures++; $display("FAIL illegal_dst_count actual=%0d required=6", xfer_count); end
  endtask

  task automatic test_full_simul();
    code_t   s [5];
    onehot_t exp_out;
    s = '{SRC_R9, SRC_R10, SRC_R11, SRC_R12, SRC_R13};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL full_clr_err actual=%b required=0", err_illegal); end
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.req_valid = 1'b1; bif.req_src = s[i]; bif.req_dst = DST_R0;
      tick();
    end
    // Present a fifth command while full, releasing hold on the same edge.
    bif.req_src = s[4]; bif.req_dst = DST_R0;
    hold = 1'b0;
    checks++; if (bif.req_ready !== 1'b0) begin failures++; $display("FAIL full_simul_ready actual=%b required=0", bif.req_ready); end
    tick();
    // Refused push, one pop: one slot free now; keep presenting the command.
    checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop_ready actual=%b required=1", bif.req_ready); end
    exp_out = onehot_t'(1) << s[0];
    checks++; if (bif.out_en !== exp_out) begin failures++; $display("FAIL full_pop0 actual=%h required=%h", bif.out_en, exp_out); end
    tick();
    bif.req_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      if (i > 1) tick();
      exp_out = onehot_t'(1) << s[i];
      checks++; if (bif.out_en !== exp_out) begin failures++; $display("FAIL full_pop%0d actual=%h required=%h", i, bif.out_en, exp_out); end
    end
    tick();
    checks++; if (bif.out_en !== 24'h0) begin failures++; $display("FAIL full_no_dup actual=%h required=000000", bif.out_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_end_busy actual=%b required=0", busy); end
  endtask

  task automatic test_back_to_back_wrap();
    onehot_t exp_out, exp_in;
    clr = 1'b1;
    tick();
    clr = 1'b0; hold = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      bif.req_valid = 1'b1;
      bif.req_src = code_t'(i % 24);
      bif.req_dst = code_t'(23 - (i % 24));
      tick();
      if (i >= 1 && i <= 16) begin
        exp_out = onehot_t'(1) << ((i - 1) % 24);
        exp_in  = onehot_t'(1) << (23 - ((i - 1) % 24));
        checks++; if (bif.out_en !== exp_out) begin failures++; $display("FAIL b2b_out_en_%0d actual=%h required=%h", i, bif.out_en, exp_out); end
        checks++; if (bif.in_en !== exp_in) begin failures++; $display("FAIL b2b_in_en_%0d actual=%h required=%h", i, bif.in_en, exp_in); end
      end
    end
    bif.req_valid = 1'b0;
    tick();
    checks++; if (xfer_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre_count actual=%h required=ffff", xfer_count); end
    bif.req_valid = 1'b1; bif.req_src = SRC_R2; bif.req_dst = DST_R3;
    tick();
    bif.req_valid = 1'b0;
    tick();
    checks++; if (xfer_count !== 16'h0000) begin failures++; $display("FAIL wrap_count actual=%h required=0000", xfer_count); end
    checks++; if (bif.out_en !== 24'h000004) begin failures++; $display("FAIL wrap_out_en actual=%h required=000004", bif.out_en); end
    checks++; if (bif.in_en !== 24'h000008) begin failures++; $display("FAIL wrap_in_en actual=%h required=000008", bif.in_en); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill_stream();
    test_illegal();
    test_full_simul();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
